// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/OneBitSubtractor.sv
// Combinational full subtractor cell; the serial top reuses one instance every cycle.
module OneBitSubtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  assign D  = A ^ B ^ BI;
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - BI, LSB first, one bit per cycle with a single subtractor cell.
// Optional macro SIGNED_OVF_EN adds the OVF output (two's-complement overflow).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             busy,
  output logic             done
`ifdef SIGNED_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic             bit_diff;
  logic             bit_bout;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  OneBitSubtractor u_bit (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .BI (bin),
    .D  (bit_diff),
    .BO (bit_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The minuend register doubles as the result register: each diff bit enters at the MSB
  // as the consumed LSB leaves, so after WIDTH shifts it holds the full difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      cnt  <= '0;
      a_sr <= '0;
      b_sr <= '0;
      bin  <= 1'b0;
      D    <= '0;
      BO   <= 1'b0;
`ifdef SIGNED_OVF_EN
      OVF  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            bin  <= BI;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= {bit_diff, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          bin  <= bit_bout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            D   <= {bit_diff, a_sr[WIDTH-1:1]};
            BO  <= bit_bout;
`ifdef SIGNED_OVF_EN
            // bin is the borrow into the MSB during the final bit.
            OVF <= bin ^ bit_bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): vector table plus multi-cycle corner sequences.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A, B, D;
  logic       BI, BO, busy, done;
`ifdef SIGNED_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] d;
    logic       bo;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BI    (BI),
    .D     (D),
    .BO    (BO),
    .busy  (busy),
    .done  (done)
`ifdef SIGNED_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drops start at the first negedge, then counts busy cycles until done appears.
  // lat is the number of negedges after the start edge; 0 means done never came.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drive_start(input logic [3:0] a, input logic [3:0] b, input logic bi);
    A     = a;
    B     = b;
    BI    = bi;
    start = 1'b1;
  endtask

  initial begin
    int lat, nbusy, npulse;

    vecs[0] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd7,  1'b0, 4'hC,  1'b1, 1'b0};
    vecs[2] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    vecs[3] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
    vecs[4] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[5] = '{4'hF,  4'hF,  1'b1, 4'hF,  1'b1, 1'b0};
    vecs[6] = '{4'd7,  4'd8,  1'b0, 4'hF,  1'b1, 1'b1};
    vecs[7] = '{4'd0,  4'hF,  1'b0, 4'd1,  1'b1, 1'b0};
    vecs[8] = '{4'd9,  4'd2,  1'b1, 4'd6,  1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; BI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_D",    D,    0);
    check("reset_BO",   BO,   0);

    // Reset wins over start in the same cycle.
    drive_start(4'd5, 4'd1, 1'b0);
    @(negedge clk);
    check("rst_priority_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive_start(vecs[i].a, vecs[i].b, vecs[i].bi);
      wait_done(lat, nbusy);
      check($sformatf("vec%0d_latency", i), lat,   5);
      check($sformatf("vec%0d_busy",    i), nbusy, 4);
      check($sformatf("vec%0d_D",       i), D,     vecs[i].d);
      check($sformatf("vec%0d_BO",      i), BO,    vecs[i].bo);
`ifdef SIGNED_OVF_EN
      check($sformatf("vec%0d_OVF",     i), ovf,   vecs[i].ovf);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_1cyc", i), done, 0);
      check($sformatf("vec%0d_D_hold",    i), D,    vecs[i].d);
    end

    // Start with new operands during RUN must be ignored.
    drive_start(4'd7, 4'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive_start(4'd1, 4'd6, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("ignore_busy", busy, 1);
    wait_done(lat, nbusy);
    check("ignore_latency", lat, 2);
    check("ignore_D",  D,  4);
    check("ignore_BO", BO, 0);
    @(negedge clk);

    // Back-to-back: start accepted in the DONE cycle, previous result held meanwhile.
    drive_start(4'd2, 4'd1, 1'b0);
    wait_done(lat, nbusy);
    check("b2b_first_latency", lat, 5);
    check("b2b_first_D", D, 1);
    drive_start(4'd6, 4'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    check("b2b_hold_D", D, 1);
    wait_done(lat, nbusy);
    check("b2b_second_latency", lat, 4);
    check("b2b_second_D",  D,  3);
    check("b2b_second_BO", BO, 0);
    @(negedge clk);

    // Reset two cycles into RUN aborts the operation.
    drive_start(4'd7, 4'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_D",    D,    0);
    check("abort_BO",   BO,   0);
    rst = 1'b0;
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("abort_no_done", npulse, 0);

    drive_start(4'hA, 4'd3, 1'b0);
    wait_done(lat, nbusy);
    check("after_abort_latency", lat, 5);
    check("after_abort_D",  D,  7);
    check("after_abort_BO", BO, 0);
`ifdef SIGNED_OVF_EN
    check("after_abort_OVF", ovf, 1);
`endif
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, WIDTH bits: the minuend.
REQ-006 The block SHALL have port B, input, WIDTH bits: the subtrahend.
REQ-007 The block SHALL have port BI, input, 1 bit: the borrow-in.
REQ-008 The block SHALL have port D, output, WIDTH bits: the difference A - B - BI modulo 2^WIDTH.
REQ-009 The block SHALL have port BO, output, 1 bit: the borrow-out, 1 when A < B + BI unsigned.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking D/BO valid.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-013 In IDLE or DONE, start=1 SHALL latch A, B and BI into internal shift registers, clear the bit counter and enter RUN.
REQ-014 While in RUN, start SHALL be ignored, and A, B and BI SHALL NOT affect the operation in progress.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first: diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin), with bout fed back as the next bin.
REQ-016 After exactly WIDTH RUN cycles the FSM SHALL enter DONE; DONE SHALL last one cycle and then return to IDLE unless start=1.
REQ-017 For start sampled at edge t, done SHALL be high in the cycle after edge t+WIDTH; with WIDTH=4 this gives a latency of 5 cycles.
REQ-018 busy SHALL equal (state==RUN).
REQ-019 done SHALL equal (state==DONE).
REQ-020 D and BO SHALL update only on the edge entering DONE and SHALL hold until the next DONE or reset.
REQ-021 A start asserted in the DONE cycle SHALL be accepted (back-to-back operation), and D/BO SHALL still hold the previous result until the next DONE.
REQ-022 Boundaries: 0-0 with BI=1 SHALL give D=all-ones and BO=1; A==B with BI=0 SHALL give D=0 and BO=0.

Reset
REQ-023 rst=1 SHALL force state=IDLE and clear D, BO, busy, done, the counter and the shift registers, all to 0.
REQ-024 rst asserted during RUN SHALL abort the operation, with no done pulse, and D/BO SHALL read 0 afterwards.
REQ-025 rst SHALL take priority over start in the same cycle.

Configuration
REQ-026 With macro SIGNED_OVF_EN defined, the block SHALL add output OVF, 1 bit, equal to the two's-complement overflow of A - B - BI (borrow into MSB XOR borrow out of MSB).
REQ-027 OVF SHALL follow the same update, hold and reset rules as BO.
REQ-028 Without SIGNED_OVF_EN, the OVF port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constant DEFAULT_WIDTH=4.
REQ-030 The per-bit logic SHALL be a sub-module OneBitSubtractor with ports A, B, BI, D and BO, instantiated once and reused each cycle.

Verification
REQ-031 The bench SHALL cover: A=7, B=3, BI=0, start pulse -> done 5 cycles later; D=4, BO=0, busy high for 4 cycles.
REQ-032 The bench SHALL cover: A=3, B=7, BI=0 -> D=0xC, BO=1; with SIGNED_OVF_EN, OVF=0.
REQ-033 The bench SHALL cover: A=8, B=1, BI=0 with SIGNED_OVF_EN -> D=7, BO=0, OVF=1.
REQ-034 The bench SHALL cover: A=0, B=0, BI=1 -> D=0xF, BO=1.
REQ-035 The bench SHALL cover: second start with different A/B during RUN -> ignored; the result matches the first operands; back-to-back start in the DONE cycle -> second result 5 cycles later.
REQ-036 The bench SHALL cover: rst asserted 2 cycles after start -> no done pulse; D=0, BO=0, busy=0 next cycle; a subsequent start operates normally.
